// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the framebuffer pixel stage.
// Free-running horizontal/vertical counters drive fb_xpos/fb_ypos. Active-low
// sync and blank leave through a PIPE_DELAY-deep delay line (legal 0..4) so they
// line up with the framebuffer's registered RGB.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 13,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 29,
  parameter int PIPE_DELAY = 1,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XBITS     = $clog2(H_TOTAL),
  localparam int YBITS     = $clog2(V_TOTAL)
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic [XBITS-1:0] fb_xpos,
  output logic [YBITS-1:0] fb_ypos,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             blank_n,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam logic [XBITS-1:0] X_LAST   = XBITS'(H_TOTAL - 1);
  localparam logic [YBITS-1:0] Y_LAST   = YBITS'(V_TOTAL - 1);
  localparam logic [XBITS-1:0] X_ACT    = XBITS'(H_ACTIVE);
  localparam logic [XBITS-1:0] HS_START = XBITS'(H_ACTIVE + H_FP);
  localparam logic [XBITS-1:0] HS_END   = XBITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YBITS-1:0] Y_ACT    = YBITS'(V_ACTIVE);
  localparam logic [YBITS-1:0] VS_START = YBITS'(V_ACTIVE + V_FP);
  localparam logic [YBITS-1:0] VS_END   = YBITS'(V_ACTIVE + V_FP + V_SYNC);

  // Inactive pattern for {hsync_n, vsync_n, blank_n}.
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  logic [XBITS-1:0] xpos_q, xpos_d;
  logic [YBITS-1:0] ypos_q, ypos_d;
  logic             frame_start_q, frame_start_d;
  logic             x_wrap, y_last, frame_wrap;
  logic             hs_raw, vs_raw, act_raw;
  logic [2:0]       raw_vec;

  // End-of-line / end-of-frame detection; >= keeps any stray value converging to 0.
  always_comb begin
    x_wrap     = (xpos_q >= X_LAST);
    y_last     = (ypos_q >= Y_LAST);
    frame_wrap = x_wrap && y_last;
  end

  // Next-state for the raster counters and the frame strobe; everything holds when pix_en is low.
  always_comb begin
    xpos_d        = xpos_q;
    ypos_d        = ypos_q;
    frame_start_d = frame_start_q;
    if (pix_en) begin
      frame_start_d = frame_wrap;
      if (x_wrap) begin
        xpos_d = '0;
        ypos_d = y_last ? '0 : ypos_q + 1'b1;
      end else begin
        xpos_d = xpos_q + 1'b1;
      end
    end
  end

  // Counter and strobe registers; reset restarts the raster at (0,0) with no strobe.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      xpos_q        <= '0;
      ypos_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      xpos_q        <= xpos_d;
      ypos_q        <= ypos_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Undelayed sync/active decode of the registered counters.
  always_comb begin
    hs_raw  = (xpos_q >= HS_START) && (xpos_q < HS_END);
    vs_raw  = (ypos_q >= VS_START) && (ypos_q < VS_END);
    act_raw = (xpos_q < X_ACT) && (ypos_q < Y_ACT);
    raw_vec = {~hs_raw, ~vs_raw, act_raw};
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      assign {hsync_n, vsync_n, blank_n} = raw_vec;
    end else begin : g_delay
      logic [2:0] pipe_q [PIPE_DELAY];
      logic [2:0] pipe_d [PIPE_DELAY];

      // Shift the decode down the delay line only on enabled pixels.
      always_comb begin
        for (int i = 0; i < PIPE_DELAY; i++) pipe_d[i] = pipe_q[i];
        if (pix_en) begin
          pipe_d[0] = raw_vec;
          for (int i = 1; i < PIPE_DELAY; i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      // Delay-line registers; reset flushes every stage to the idle pattern so no stale pulse escapes.
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= SYNC_IDLE;
        end else begin
          for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_d[i];
        end
      end

      assign {hsync_n, vsync_n, blank_n} = pipe_q[PIPE_DELAY-1];
    end
  endgenerate

  assign fb_xpos     = xpos_q;
  assign fb_ypos     = ypos_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Frame count steps on the same edge that raises frame_start; natural 16-bit wrap.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (pix_en && frame_wrap) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  // Frame counter register.
  always_ff @(posedge vga_clk) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator directly upstream of the framebuffer pixel stage.
- Free-runs horizontal/vertical counters on vga_clk and drives fb_xpos/fb_ypos into the framebuffer.
- Produces active-low HSYNC, VSYNC and BLANK for the VGA DAC, delayed by PIPE_DELAY so they align with the framebuffer's registered RGB.
- Default timing is the 800x480 panel mode; frame_start is a per-frame strobe for downstream logic.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 13, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- PIPE_DELAY, 1, register stages on hsync_n/vsync_n/blank_n (legal range 0..4); matches framebuffer latency
- Derived localparams (not overridable): H_TOTAL = sum of H_* = 1056; V_TOTAL = sum of V_* = 525; XBITS = $clog2(H_TOTAL) = 11; YBITS = $clog2(V_TOTAL) = 10

Ports:
- vga_clk  input  1  pixel clock
- reset  input  1  synchronous, active-high reset
- pix_en  input  1  pixel clock enable; low = everything holds
- fb_xpos  output  XBITS  horizontal counter (0..H_TOTAL-1)
- fb_ypos  output  YBITS  vertical counter (0..V_TOTAL-1)
- hsync_n  output  1  horizontal sync, active low, delayed PIPE_DELAY
- vsync_n  output  1  vertical sync, active low, delayed PIPE_DELAY
- blank_n  output  1  1 = active video, delayed PIPE_DELAY
- frame_start  output  1  one-cycle strobe, undelayed

Behaviour:
- One clock (vga_clk); reset is synchronous and active-high.
- Reset values (on the vga_clk edge with reset=1):
  - fb_xpos=0, fb_ypos=0, frame_start=0.
  - hsync_n=1, vsync_n=1, blank_n=0.
  - All PIPE_DELAY stages are loaded with the inactive values (1,1,0).
- Reset has priority over pix_en. Reset mid-frame restarts at (0,0) on the next cycle and produces no partial sync pulses beyond that cycle.
- Counters advance only when pix_en=1 (registered):
  - fb_xpos increments by 1; at H_TOTAL-1 it wraps to 0 and fb_ypos increments.
  - fb_ypos wraps V_TOTAL-1 -> 0 only on the cycle where fb_xpos wraps.
  - No other counter values are reachable.
- Raw (undelayed) decode from the registered counters:
  - hs_raw active when H_ACTIVE+H_FP <= fb_xpos < H_ACTIVE+H_FP+H_SYNC (840..967).
  - vs_raw active when V_ACTIVE+V_FP <= fb_ypos < V_ACTIVE+V_FP+V_SYNC (493..495). It changes only at the line wrap, never mid-line.
  - act_raw = (fb_xpos < H_ACTIVE) and (fb_ypos < V_ACTIVE).
- Delay line:
  - hsync_n = ~hs_raw, vsync_n = ~vs_raw, blank_n = act_raw, each delayed by exactly PIPE_DELAY pix_en-qualified stages.
  - Stages shift only when pix_en=1.
  - PIPE_DELAY=0: outputs are combinational decodes of the registered counters.
- frame_start:
  - Registered, =1 for exactly one pix_en-qualified cycle, while (fb_xpos,fb_ypos)=(0,0) following a wrap.
  - Not asserted in the first cycle after reset.
  - pix_en=0 while at (0,0): frame_start holds its value; it does not re-pulse.
- Latency: a counter value appearing on fb_xpos/fb_ypos at cycle t has its matching sync/blank at cycle t+PIPE_DELAY.
- Per frame: 1056*525 = 554400 enabled cycles; hsync low 128 cycles/line; vsync low 3 lines.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt [15:0]; reset 0.
  - Increments in the same cycle frame_start is asserted; wraps 65535 -> 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles with pix_en=1 -> fb_xpos=0, fb_ypos=0, hsync_n=1, vsync_n=1, blank_n=0, frame_start=0; released -> fb_xpos=1 after one cycle; blank_n=1 from cycle PIPE_DELAY (counter value 0 propagated).
- pix_en=1, line 0, PIPE_DELAY=1 -> blank_n falls when fb_xpos=801; hsync_n low while fb_xpos=841..968 (128 cycles); fb_xpos 1055 -> 0 with fb_ypos 0 -> 1.
- Run to fb_ypos=492, xpos=1055 -> next cycle fb_ypos=493 and vs_raw asserted; vsync_n low for exactly 3*1056 cycles; at (1055,524) -> (0,0) and frame_start=1 for one cycle.
- Toggle pix_en 0/1 every other cycle across an hsync edge -> counters and delay line advance only on enabled cycles; hsync pulse spans 128 enabled cycles (256 clocks).
- Assert reset at (500,300) -> next cycle (0,0), sync/blank at inactive values; next frame_start only after a full 554400-cycle frame.
- With VGA_TIMING_FRAME_CNT_EN defined, run 3 frames -> frame_cnt 0,1,2,3 stepping with each frame_start; preset via force to 65535 -> wraps to 0.
